// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NREQ requesters, the arbiter and the FIFO write port.
//
// Handshakes (both valid/ready style):
//   requester -> arbiter : word i moves in a cycle with req[i] & gnt[i];
//                          req is a level held until granted, gnt is one-hot.
//   arbiter   -> FIFO    : word moves in a cycle with insert & ~full;
//                          insert/dataIn hold steady while full is high.
//
// Signals:
//   req, req_data, flush_req, full   : into the arbiter
//   gnt, insert, dataIn, flush,
//   flush_done, word_cnt             : out of the arbiter
//   state_dbg                        : arbiter FSM state (0 = RUN, 1 = FLUSH)
interface fifo_wr_arbiter_if #(
  parameter int DATASIZE = 32,
  parameter int NREQ     = 4
);
  logic [NREQ-1:0]          req;
  logic [NREQ*DATASIZE-1:0] req_data;
  logic [NREQ-1:0]          gnt;
  logic                     flush_req;
  logic                     full;
  logic                     insert;
  logic [DATASIZE-1:0]      dataIn;
  logic                     flush;
  logic                     flush_done;
  logic [15:0]              word_cnt;
  logic                     state_dbg;

  // Environment side: requesters plus the FIFO's full flag.
  modport master (
    output req, req_data, flush_req, full,
    input  gnt, insert, dataIn, flush, flush_done, word_cnt, state_dbg
  );

  // Arbiter side.
  modport slave (
    input  req, req_data, flush_req, full,
    output gnt, insert, dataIn, flush, flush_done, word_cnt, state_dbg
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ requesters.
// The granted word is registered into a one-entry output stage that holds
// while the FIFO is full. A flush request discards the held word and drives
// the FIFO flush line for FLUSH_CYCLES cycles, then pulses flush_done and
// restarts arbitration from requester 0 with the word counter cleared.
//
// Ports:
//   clk  : FIFO write clock
//   rst  : synchronous, active-high reset
//   bus  : fifo_wr_arbiter_if.slave (requests, grants, FIFO write port,
//          flush control, word counter, FSM state)
module fifo_wr_arbiter #(
  parameter int DATASIZE     = 32,
  parameter int NREQ         = 4,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  fifo_wr_arbiter_if.slave    bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [PW-1:0]       ptr, ptr_nxt;
  logic [3:0]          fcnt;
  logic                slot_free;
  logic                flush_last;
  logic                grant_ok;
  logic                found;
  logic [NREQ-1:0]     gnt_c;
  logic [DATASIZE-1:0] win_data;

  // Output stage can accept a word when empty or draining this cycle.
  assign slot_free  = ~bus.insert | ~bus.full;
  assign flush_last = (state == FLUSH) && (fcnt == 4'(FLUSH_CYCLES - 1));
  assign grant_ok   = ~rst && (state == RUN) && slot_free && ~bus.flush_req;

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (bus.flush_req) state_nxt = FLUSH;
      FLUSH:   if (flush_last)    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Round-robin scan: first pass covers indices ptr..NREQ-1, second pass
  // wraps to 0..ptr-1, so the first set request at or after ptr wins.
  always_comb begin
    gnt_c    = '0;
    win_data = '0;
    ptr_nxt  = ptr;
    found    = 1'b0;
    if (grant_ok) begin
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!found && bus.req[i] &&
              ((p == 0) ? (PW'(i) >= ptr) : (PW'(i) < ptr))) begin
            found    = 1'b1;
            gnt_c[i] = 1'b1;
            win_data = bus.req_data[i*DATASIZE +: DATASIZE];
            ptr_nxt  = (i == NREQ - 1) ? '0 : PW'(i + 1);
          end
        end
      end
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      ptr            <= '0;
      fcnt           <= '0;
      bus.insert     <= 1'b0;
      bus.dataIn     <= '0;
      bus.flush      <= 1'b0;
      bus.flush_done <= 1'b0;
      bus.word_cnt   <= '0;
    end else begin
      state          <= state_nxt;
      bus.flush_done <= flush_last;

      // A word leaving on the flush-entry cycle still counts; the clear
      // happens only as the flush sequence completes.
      if (flush_last)
        bus.word_cnt <= '0;
      else if (bus.insert && !bus.full)
        bus.word_cnt <= bus.word_cnt + 16'd1;

      case (state)
        RUN: begin
          fcnt <= '0;
          if (bus.flush_req) begin
            bus.insert <= 1'b0;   // held word is discarded
            bus.flush  <= 1'b1;
          end else if (found) begin
            bus.insert <= 1'b1;
            bus.dataIn <= win_data;
            ptr        <= ptr_nxt;
          end else if (slot_free) begin
            bus.insert <= 1'b0;
          end
        end
        FLUSH: begin
          bus.insert <= 1'b0;
          if (flush_last) begin
            bus.flush <= 1'b0;
            ptr       <= '0;
            fcnt      <= '0;
          end else begin
            fcnt <= fcnt + 4'd1;
          end
        end
        default: begin
          bus.insert <= 1'b0;
          bus.flush  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (DATASIZE=32, NREQ=4, FLUSH_CYCLES=4).
// Inputs change 1 time unit after posedge; outputs are compared at negedge.
module tb_fifo_wr_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.DATASIZE(32), .NREQ(4)) bus ();

  fifo_wr_arbiter #(
    .DATASIZE(32), .NREQ(4), .FLUSH_CYCLES(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] dwords [4];
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        pre_rst;
    logic [3:0]  req;
    logic        full;
    logic        fr;
    logic [3:0]  gnt;
    logic        ins;
    logic [1:0]  didx;
    logic        flush;
    logic        done;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [20];

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst           = 1'b1;
    bus.req       = 4'b1111;
    bus.full      = 1'b0;
    bus.flush_req = 1'b0;
    @(negedge clk);
    chk("rst.gnt", 32'(bus.gnt), 32'h0);
    @(posedge clk); #1;
    rst     = 1'b0;
    bus.req = 4'b0000;
    chk("rst.insert",   32'(bus.insert),     32'h0);
    chk("rst.dataIn",   bus.dataIn,          32'h0);
    chk("rst.flush",    32'(bus.flush),      32'h0);
    chk("rst.done",     32'(bus.flush_done), 32'h0);
    chk("rst.word_cnt", 32'(bus.word_cnt),   32'h0);
    chk("rst.state",    32'(bus.state_dbg),  32'h0);
  endtask

  // One cycle: drive inputs, compare outputs at negedge, advance past posedge.
  task automatic cyc(input string tag, input logic r, input logic [3:0] rq,
                     input logic f, input logic fr,
                     input logic [3:0] eg, input logic ei, input logic [1:0] ed,
                     input logic efl, input logic edn, input logic [15:0] ec);
    rst           = r;
    bus.req       = rq;
    bus.full      = f;
    bus.flush_req = fr;
    @(negedge clk);
    chk({tag, ".gnt"},    32'(bus.gnt),        32'(eg));
    chk({tag, ".insert"}, 32'(bus.insert),     32'(ei));
    if (ei) chk({tag, ".dataIn"}, bus.dataIn, dwords[ed]);
    chk({tag, ".flush"},  32'(bus.flush),      32'(efl));
    chk({tag, ".done"},   32'(bus.flush_done), 32'(edn));
    chk({tag, ".cnt"},    32'(bus.word_cnt),   32'(ec));
    chk({tag, ".state"},  32'(bus.state_dbg),  32'(efl));
    @(posedge clk); #1;
  endtask

  initial begin
    dwords[0] = 32'h1111_0000;
    dwords[1] = 32'h2222_1111;
    dwords[2] = 32'h3333_2222;
    dwords[3] = 32'h4444_3333;
    bus.req_data  = {dwords[3], dwords[2], dwords[1], dwords[0]};
    bus.req       = '0;
    bus.full      = 1'b0;
    bus.flush_req = 1'b0;

    //         pre  req      full fr  gnt      ins didx flush done cnt
    // Rotation with all four requesting, full=0.
    tbl[0]  = '{1, 4'b1111, 0, 0, 4'b0001, 0, 0, 0, 0, 16'd0};
    tbl[1]  = '{0, 4'b1111, 0, 0, 4'b0010, 1, 0, 0, 0, 16'd0};
    tbl[2]  = '{0, 4'b1111, 0, 0, 4'b0100, 1, 1, 0, 0, 16'd1};
    tbl[3]  = '{0, 4'b1111, 0, 0, 4'b1000, 1, 2, 0, 0, 16'd2};
    tbl[4]  = '{0, 4'b1111, 0, 0, 4'b0001, 1, 3, 0, 0, 16'd3};
    tbl[5]  = '{0, 4'b1111, 0, 0, 4'b0010, 1, 0, 0, 0, 16'd4};
    tbl[6]  = '{0, 4'b1111, 0, 0, 4'b0100, 1, 1, 0, 0, 16'd5};
    tbl[7]  = '{0, 4'b1111, 0, 0, 4'b1000, 1, 2, 0, 0, 16'd6};
    tbl[8]  = '{0, 4'b0000, 0, 0, 4'b0000, 1, 3, 0, 0, 16'd7};
    tbl[9]  = '{0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, 16'd8};
    // Stall under full for 5 cycles with req=0101.
    tbl[10] = '{1, 4'b0101, 0, 0, 4'b0001, 0, 0, 0, 0, 16'd0};
    tbl[11] = '{0, 4'b0101, 1, 0, 4'b0000, 1, 0, 0, 0, 16'd0};
    tbl[12] = '{0, 4'b0101, 1, 0, 4'b0000, 1, 0, 0, 0, 16'd0};
    tbl[13] = '{0, 4'b0101, 1, 0, 4'b0000, 1, 0, 0, 0, 16'd0};
    tbl[14] = '{0, 4'b0101, 1, 0, 4'b0000, 1, 0, 0, 0, 16'd0};
    tbl[15] = '{0, 4'b0101, 1, 0, 4'b0000, 1, 0, 0, 0, 16'd0};
    tbl[16] = '{0, 4'b0101, 0, 0, 4'b0100, 1, 0, 0, 0, 16'd0};
    tbl[17] = '{0, 4'b0101, 0, 0, 4'b0001, 1, 2, 0, 0, 16'd1};
    tbl[18] = '{0, 4'b0000, 0, 0, 4'b0000, 1, 0, 0, 0, 16'd2};
    tbl[19] = '{0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, 16'd3};

    @(posedge clk); #1;
    for (int k = 0; k < 20; k++) begin
      if (tbl[k].pre_rst) do_reset();
      cyc($sformatf("tbl%0d", k), 1'b0, tbl[k].req, tbl[k].full, tbl[k].fr,
          tbl[k].gnt, tbl[k].ins, tbl[k].didx, tbl[k].flush, tbl[k].done, tbl[k].cnt);
    end

    // Flush pulse while a word is held under full; ptr restarts at 0.
    do_reset();
    cyc("fl.c0", 0, 4'b1111, 0, 0, 4'b0001, 0, 0, 0, 0, 16'd0);
    cyc("fl.c1", 0, 4'b1111, 0, 0, 4'b0010, 1, 0, 0, 0, 16'd0);
    cyc("fl.c2", 0, 4'b1111, 1, 1, 4'b0000, 1, 1, 0, 0, 16'd1);
    cyc("fl.c3", 0, 4'b1111, 0, 0, 4'b0000, 0, 0, 1, 0, 16'd1);
    cyc("fl.c4", 0, 4'b1111, 0, 0, 4'b0000, 0, 0, 1, 0, 16'd1);
    cyc("fl.c5", 0, 4'b1111, 0, 0, 4'b0000, 0, 0, 1, 0, 16'd1);
    cyc("fl.c6", 0, 4'b1111, 0, 0, 4'b0000, 0, 0, 1, 0, 16'd1);
    cyc("fl.c7", 0, 4'b1111, 0, 0, 4'b0001, 0, 0, 0, 1, 16'd0);
    cyc("fl.c8", 0, 4'b0000, 0, 0, 4'b0000, 1, 0, 0, 0, 16'd0);
    cyc("fl.c9", 0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, 16'd1);

    // flush_req held for 10 cycles: two back-to-back sequences; the word
    // leaving on the entry cycle is counted before the clear.
    do_reset();
    cyc("fh.c0",  0, 4'b1111, 0, 0, 4'b0001, 0, 0, 0, 0, 16'd0);
    cyc("fh.c1",  0, 4'b1111, 0, 1, 4'b0000, 1, 0, 0, 0, 16'd0);
    for (int k = 2; k <= 5; k++)
      cyc($sformatf("fh.c%0d", k), 0, 4'b1111, 0, 1, 4'b0000, 0, 0, 1, 0, 16'd1);
    cyc("fh.c6",  0, 4'b1111, 0, 1, 4'b0000, 0, 0, 0, 1, 16'd0);
    for (int k = 7; k <= 10; k++)
      cyc($sformatf("fh.c%0d", k), 0, 4'b1111, 0, 1, 4'b0000, 0, 0, 1, 0, 16'd0);
    cyc("fh.c11", 0, 4'b1111, 0, 0, 4'b0001, 0, 0, 0, 1, 16'd0);
    cyc("fh.c12", 0, 4'b1111, 0, 0, 4'b0010, 1, 0, 0, 0, 16'd0);

    // Reset in the 2nd flush cycle aborts the flush without flush_done.
    do_reset();
    cyc("rf.c0", 0, 4'b0000, 0, 1, 4'b0000, 0, 0, 0, 0, 16'd0);
    cyc("rf.c1", 0, 4'b0000, 0, 0, 4'b0000, 0, 0, 1, 0, 16'd0);
    cyc("rf.c2", 1, 4'b1111, 0, 0, 4'b0000, 0, 0, 1, 0, 16'd0);
    cyc("rf.c3", 0, 4'b1000, 0, 0, 4'b1000, 0, 0, 0, 0, 16'd0);
    cyc("rf.c4", 0, 4'b0000, 0, 0, 4'b0000, 1, 3, 0, 0, 16'd0);
    cyc("rf.c5", 0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, 16'd1);
    cyc("rf.c6", 0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, 16'd1);

    // 65537 single writes: counter passes 0xFFFF -> 0x0000 -> 0x0001.
    do_reset();
    bus.req = 4'b0001;
    repeat (65537) begin
      @(posedge clk); #1;
    end
    cyc("wrap.c0", 0, 4'b0000, 0, 0, 4'b0000, 1, 0, 0, 0, 16'h0000);
    cyc("wrap.c1", 0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, 16'h0001);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
